// File: rtl/phase_center_pkg.sv
// phase_center_pkg: load_reg field positions, default widths and FSM state type for the phase-centre loader
package phase_center_pkg;
    localparam int LOAD_BIT        = 31;
    localparam int CLEAR_BIT       = 30;
    localparam int CHAN_LSB        = 16;
    localparam int CENTRE_LSB      = 0;
    localparam int DEF_N_CHAN_BITS = 8;
    localparam int DEF_PHASE_W     = 16;
    typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/phase_center_ram.sv
// phase_center_ram: simple dual-port read-first centre RAM with a registered read port
module phase_center_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;
    // Same-address write and read in one cycle returns the word held before the write
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/phase_center_loader.sv
// phase_center_loader: decodes load/clear commands into a per-channel centre RAM and subtracts centres from the phase stream; PHASE_CENTER_SAT_EN selects saturating instead of wrapping subtract
module phase_center_loader
    import phase_center_pkg::*;
#(
    parameter int N_CHAN_BITS = DEF_N_CHAN_BITS,
    parameter int PHASE_W     = DEF_PHASE_W
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic [31:0]            load_reg,
    input  logic                   in_valid,
    input  logic [N_CHAN_BITS-1:0] in_chan,
    input  logic [PHASE_W-1:0]     in_phase,
    output logic                   out_valid,
    output logic [N_CHAN_BITS-1:0] out_chan,
    output logic [PHASE_W-1:0]     out_phase,
    output logic                   busy,
    output logic [15:0]            load_count
);
    logic [31:0]            r0_q, r1_q;
    logic [1:0]             acc_q;
    logic                   stable, ld_edge, clr_edge;
    logic                   ld_q, clr_q;
    logic [N_CHAN_BITS-1:0] ld_chan_q;
    logic [PHASE_W-1:0]     ld_cen_q;
    state_e                 state_q;
    logic [N_CHAN_BITS-1:0] addr_q;
    logic [15:0]            count_q;
    logic                   we;
    logic [N_CHAN_BITS-1:0] waddr;
    logic [PHASE_W-1:0]     wdata, rdata, centre, res;
    logic                   v1_q, zero1_q;
    logic [N_CHAN_BITS-1:0] chan1_q;
    logic [PHASE_W-1:0]     phase1_q;
    logic                   out_valid_q;
    logic [N_CHAN_BITS-1:0] out_chan_q;
    logic [PHASE_W-1:0]     out_phase_q;

    // acc_q keeps only the {load, clear} bits of the last accepted word; edges are judged against it
    assign stable   = r0_q == r1_q;
    assign ld_edge  = stable && r1_q[LOAD_BIT] && !acc_q[1];
    assign clr_edge = stable && r1_q[CLEAR_BIT] && !acc_q[0];

    // Two-stage capture of the register word and registered command pulses
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r0_q      <= '0;
            r1_q      <= '0;
            acc_q     <= '0;
            ld_q      <= 1'b0;
            clr_q     <= 1'b0;
            ld_chan_q <= '0;
            ld_cen_q  <= '0;
        end else begin
            r0_q      <= load_reg;
            r1_q      <= r0_q;
            acc_q     <= stable ? {r1_q[LOAD_BIT], r1_q[CLEAR_BIT]} : acc_q;
            ld_q      <= ld_edge;
            clr_q     <= clr_edge;
            ld_chan_q <= r1_q[CHAN_LSB +: N_CHAN_BITS];
            ld_cen_q  <= r1_q[CENTRE_LSB +: PHASE_W];
        end
    end

    // Sweep/idle controller; reset lands in a fresh sweep, clear beats a simultaneous load
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= CLEAR;
            addr_q  <= '0;
            count_q <= '0;
        end else if (state_q == CLEAR) begin
            addr_q  <= addr_q + N_CHAN_BITS'(1);
            state_q <= (addr_q == '1) ? IDLE : CLEAR;
        end else if (clr_q) begin
            state_q <= CLEAR;
            addr_q  <= '0;
        end else if (ld_q) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign we         = (state_q == CLEAR) || (ld_q && !clr_q);
    assign waddr      = (state_q == CLEAR) ? addr_q : ld_chan_q;
    assign wdata      = (state_q == CLEAR) ? '0 : ld_cen_q;
    assign busy       = state_q == CLEAR;
    assign load_count = count_q;

    phase_center_ram #(.AW(N_CHAN_BITS), .DW(PHASE_W)) u_ram (
        .clk_i   (user_clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (in_chan),
        .rdata_o (rdata)
    );

    // Stream stage 1: sample fields travel alongside the RAM read, with the busy state at read time
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            v1_q     <= 1'b0;
            zero1_q  <= 1'b0;
            chan1_q  <= '0;
            phase1_q <= '0;
        end else begin
            v1_q     <= in_valid;
            zero1_q  <= busy;
            chan1_q  <= in_chan;
            phase1_q <= in_phase;
        end
    end

    assign centre = zero1_q ? '0 : rdata;

`ifdef PHASE_CENTER_SAT_EN
    logic [PHASE_W:0] diff;
    assign diff = {phase1_q[PHASE_W-1], phase1_q} - {centre[PHASE_W-1], centre};
    assign res  = (diff[PHASE_W] == diff[PHASE_W-1]) ? diff[PHASE_W-1:0]
                                                     : {diff[PHASE_W], {(PHASE_W-1){~diff[PHASE_W]}}};
`else
    logic [PHASE_W-1:0] diff;
    assign diff = phase1_q - centre;
    assign res  = diff;
`endif

    // Stream stage 2: registered difference
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_phase_q <= '0;
        end else begin
            out_valid_q <= v1_q;
            out_chan_q  <= chan1_q;
            out_phase_q <= res;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_phase = out_phase_q;
endmodule
